// File: rtl/serial_echo_pkg.sv
// -----------------------------------------------------------------------------
// serial_echo_pkg
//   Shared types and helpers for the serial echo device.
//   rx_state_e  : deframer states (idle, data bits, stop bit)
//   tx_state_e  : serialiser states (idle, start, data bits, parity, gap)
//   even_parity : parity bit that makes the total number of ones even
// -----------------------------------------------------------------------------
package serial_echo_pkg;

   // Widest payload the parity helper accepts; callers zero-extend into it.
   localparam int PAR_W = 64;

   typedef enum logic [1:0] {
      R_IDLE,
      R_DATA,
      R_STOP
   } rx_state_e;

   typedef enum logic [2:0] {
      T_IDLE,
      T_START,
      T_DATA,
      T_PAR,
      T_GAP
   } tx_state_e;

   function automatic logic even_parity(input logic [PAR_W-1:0] v);
      return ^v;
   endfunction

endpackage : serial_echo_pkg

// File: rtl/serial_echo_fifo.sv
// -----------------------------------------------------------------------------
// serial_echo_fifo
//   Synchronous FIFO buffering deframed words between the RX and TX sides.
//   Pointers carry one extra MSB so full and empty are distinguishable when
//   the index bits match.
// Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write request and data (ignored when full unless popping)
//   pop, dout  : read request and head-of-queue data (dout valid when !empty)
//   full/empty : occupancy flags
//   level      : words currently held, 0..DEPTH
// -----------------------------------------------------------------------------
module serial_echo_fifo
   import serial_echo_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic [DATA_W-1:0]      din,
   output logic [DATA_W-1:0]      dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW:0]       wr_ptr;
   logic [AW:0]       rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign level   = wr_ptr - rd_ptr;
   assign do_pop  = pop && !empty;
   // A pop in the same cycle frees the slot, so a full FIFO can still accept.
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr[AW-1:0]];

   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // NOTE: the storage array has no reset; the pointers alone define which
   // entries are valid, and leaving it unreset lets it map onto plain RAM/flops.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule : serial_echo_fifo

// File: rtl/serial_echo_device.sv
// -----------------------------------------------------------------------------
// serial_echo_device
//   Deframes words arriving bit-serially on b, buffers them, and re-serialises
//   each one (XORed with XOR_MASK) onto a with a start bit, an even-parity bit
//   and a one-cycle gap.
//   Frame on b : start(1), DATA_W bits LSB first, stop(0).
//   Frame on a : start(1), DATA_W bits LSB first, parity, gap(0).
// Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   b          : serial stimulus line, idles low
//   a          : registered serial response line, idles low
//   frame_err  : one-cycle pulse when a stop bit is 1 (frame dropped)
//   overflow   : sticky, set when a good frame is dropped on a full FIFO
//   fifo_level : words currently buffered
//   frames_rx  : frames accepted into the FIFO, wraps at 16 bits
// -----------------------------------------------------------------------------
module serial_echo_device
   import serial_echo_pkg::*;
#(
   parameter int                DATA_W     = 8,
   parameter int                FIFO_DEPTH = 4,
   parameter logic [DATA_W-1:0] XOR_MASK   = '0
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        b,
   output logic                        a,
   output logic                        frame_err,
   output logic                        overflow,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic [15:0]                 frames_rx
);

   localparam int               CNT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_W - 1);

   // ---------------------------------------------------------------- RX side
   rx_state_e         rx_state, rx_next;
   logic [DATA_W-1:0] rx_shift;
   logic [CNT_W-1:0]  rx_cnt;
   logic              push_req;
   logic              stop_bad;

   // ---------------------------------------------------------------- TX side
   tx_state_e         tx_state, tx_next;
   logic [DATA_W-1:0] tx_shift;
   logic [DATA_W-1:0] tx_word;
   logic [CNT_W-1:0]  tx_cnt;
   logic              tx_par;
   logic              tx_pop;
   logic              a_next;

   // ---------------------------------------------------------------- FIFO
   logic              fifo_push;
   logic              fifo_full;
   logic              fifo_empty;
   logic [DATA_W-1:0] fifo_dout;
   logic              drop;

   // A good frame is dropped only when the FIFO is full and TX is not freeing
   // a slot in the same cycle.
   assign fifo_push = push_req && (!fifo_full || tx_pop);
   assign drop      = push_req && fifo_full && !tx_pop;
   assign tx_word   = fifo_dout ^ XOR_MASK;

   serial_echo_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_push),
      .pop   (tx_pop),
      .din   (rx_shift),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   // ---------------------------------------------------------------- RX FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rx_state <= R_IDLE;
      else        rx_state <= rx_next;
   end

   // NOTE: every signal driven here gets a default first, so no path through
   // the case leaves one unassigned and no latch is inferred.
   always_comb begin
      rx_next  = rx_state;
      push_req = 1'b0;
      stop_bad = 1'b0;
      case (rx_state)
         R_IDLE:  if (b) rx_next = R_DATA;
         R_DATA:  if (rx_cnt == LAST) rx_next = R_STOP;
         R_STOP: begin
            push_req = ~b;
            stop_bad = b;
            rx_next  = R_IDLE;
         end
         default: rx_next = R_IDLE;
      endcase
   end

   // Data arrives LSB first, so shift in from the top.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_shift <= '0;
         rx_cnt   <= '0;
      end else begin
         case (rx_state)
            R_IDLE: rx_cnt <= '0;
            R_DATA: begin
               rx_shift <= {b, rx_shift[DATA_W-1:1]};
               rx_cnt   <= rx_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------------- status
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_err <= 1'b0;
         overflow  <= 1'b0;
         frames_rx <= '0;
      end else begin
         frame_err <= stop_bad;
         if (drop)      overflow  <= 1'b1;
         if (fifo_push) frames_rx <= frames_rx + 16'd1;
      end
   end

   // ---------------------------------------------------------------- TX FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tx_state <= T_IDLE;
      else        tx_state <= tx_next;
   end

   // a_next is the value a carries while the FSM sits in tx_next, so the line
   // is registered yet aligned with the state it belongs to.
   always_comb begin
      tx_next = tx_state;
      tx_pop  = 1'b0;
      a_next  = 1'b0;
      case (tx_state)
         T_IDLE: begin
            if (!fifo_empty) begin
               tx_pop  = 1'b1;
               tx_next = T_START;
               a_next  = 1'b1;
            end
         end
         T_START: begin
            tx_next = T_DATA;
            a_next  = tx_shift[0];
         end
         T_DATA: begin
            if (tx_cnt == LAST) begin
               tx_next = T_PAR;
               a_next  = tx_par;
            end else begin
               a_next  = tx_shift[0];
            end
         end
         T_PAR:   tx_next = T_GAP;
         T_GAP:   tx_next = T_IDLE;
         default: tx_next = T_IDLE;
      endcase
   end

   // tx_shift[0] always holds the next bit to put on a.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_shift <= '0;
         tx_par   <= 1'b0;
         tx_cnt   <= '0;
         a        <= 1'b0;
      end else begin
         a <= a_next;
         if (tx_pop) begin
            tx_shift <= tx_word;
            tx_par   <= even_parity(PAR_W'(tx_word));
         end else if (tx_state == T_START || tx_state == T_DATA) begin
            tx_shift <= tx_shift >> 1;
         end
         if (tx_state == T_START)     tx_cnt <= '0;
         else if (tx_state == T_DATA) tx_cnt <= tx_cnt + 1'b1;
      end
   end

endmodule : serial_echo_device

// File: tb/tb_serial_echo_device.sv
// -----------------------------------------------------------------------------
// tb_serial_echo_device
//   Two instances share clk/rst_n/b: one with XOR_MASK=0, one with 8'hFF.
//   A queue-based reference model (words in a FIFO queue, echoed bit streams
//   scheduled into queues, TX availability tracked as a cycle number) is
//   compared against every output after every clock edge. Table vectors and
//   hand-timed sequences add fixed expectations on top.
// -----------------------------------------------------------------------------
module tb_serial_echo_device;

   localparam int         DW     = 8;
   localparam int         DEPTH  = 4;
   localparam logic [7:0] MASK1  = 8'hFF;
   localparam int         TX_PER = DW + 4;   // start..gap plus the idle pop cycle

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        b = 1'b0;
   logic        a0, a1, ferr0, ferr1, ovf0, ovf1;
   logic [2:0]  lvl0, lvl1;
   logic [15:0] frx0, frx1;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   serial_echo_device #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .XOR_MASK(8'h00)) dut0 (
      .clk(clk), .rst_n(rst_n), .b(b), .a(a0), .frame_err(ferr0),
      .overflow(ovf0), .fifo_level(lvl0), .frames_rx(frx0)
   );

   serial_echo_device #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .XOR_MASK(MASK1)) dut1 (
      .clk(clk), .rst_n(rst_n), .b(b), .a(a1), .frame_err(ferr1),
      .overflow(ovf1), .fifo_level(lvl1), .frames_rx(frx1)
   );

   // ------------------------------------------------------------ reference model
   logic [7:0] m_q[$];
   bit         ea0[$];
   bit         ea1[$];
   int         m_cyc;
   int         m_next_pop;
   bit         m_err, m_ovf, m_a0, m_a1;
   int         m_rx;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: actual=%0h required=%0h (model cycle %0d)", name, act, exp, m_cyc);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      ea0.delete();
      ea1.delete();
      m_cyc = 0;
      m_next_pop = 0;
      m_err = 0;
      m_ovf = 0;
      m_a0 = 0;
      m_a1 = 0;
      m_rx = 0;
   endtask

   // One clock edge. stop_ev marks the edge that samples a frame's stop bit.
   task automatic model_edge(input bit stop_ev, input logic bv, input logic [7:0] w);
      bit         do_pop, was_full;
      logic [7:0] pw, px;
      do_pop   = (m_q.size() != 0) && (m_cyc >= m_next_pop);
      was_full = (m_q.size() == DEPTH);
      if (do_pop) begin
         pw = m_q.pop_front();
         px = pw ^ MASK1;
         ea0.push_back(1'b1);
         ea1.push_back(1'b1);
         for (int i = 0; i < DW; i++) begin
            ea0.push_back(pw[i]);
            ea1.push_back(px[i]);
         end
         ea0.push_back(^pw);
         ea1.push_back(^px);
         ea0.push_back(1'b0);
         ea1.push_back(1'b0);
         m_next_pop = m_cyc + TX_PER;
      end
      m_err = stop_ev && bv;
      if (stop_ev && !bv) begin
         if (!was_full || do_pop) begin
            m_q.push_back(w);
            m_rx = (m_rx + 1) % 65536;
         end else begin
            m_ovf = 1;
         end
      end
      m_a0 = (ea0.size() != 0) ? ea0.pop_front() : 1'b0;
      m_a1 = (ea1.size() != 0) ? ea1.pop_front() : 1'b0;
      m_cyc++;
   endtask

   task automatic compare_all();
      logic [2:0] ml;
      ml = 3'(m_q.size());
      check("a_plain",    32'(a0), 32'(m_a0));
      check("a_masked",   32'(a1), 32'(m_a1));
      check("frame_err",  32'({ferr1, ferr0}), 32'({m_err, m_err}));
      check("overflow",   32'({ovf1, ovf0}), 32'({m_ovf, m_ovf}));
      check("fifo_level", 32'({lvl1, lvl0}), 32'({ml, ml}));
      check("frames_rx",  {frx1, frx0}, {16'(m_rx), 16'(m_rx)});
   endtask

   // ------------------------------------------------------------ stimulus
   task automatic step(input logic bv, input bit stop_ev, input logic [7:0] w);
      b = bv;
      @(posedge clk);
      model_edge(stop_ev, bv, w);
      #1;
      compare_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
   endtask

   task automatic send_frame(input logic [7:0] data, input logic stop);
      step(1'b1, 1'b0, 8'h00);
      for (int i = 0; i < DW; i++) step(data[i], 1'b0, 8'h00);
      step(stop, 1'b1, data);
   endtask

   // Asserts reset between edges and checks the outputs clear without a clock.
   task automatic apply_reset(input string tag);
      b = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check({tag, "_a"},         32'({a1, a0}), 32'd0);
      check({tag, "_flags"},     32'({ferr1, ferr0, ovf1, ovf0}), 32'd0);
      check({tag, "_level"},     32'({lvl1, lvl0}), 32'd0);
      check({tag, "_frames_rx"}, {frx1, frx0}, 32'd0);
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // ------------------------------------------------------------ vectors
   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic       exp_err;
      logic [7:0] exp_w0;
      logic [7:0] exp_w1;
      logic       exp_par;
   } vec_t;

   localparam int NV = 8;
   vec_t vecs[NV];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, required finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [11:0] cap0, cap1;
      int          n_good;

      vecs[0] = '{8'hA5, 1'b0, 1'b0, 8'hA5, 8'h5A, 1'b0};
      vecs[1] = '{8'h3C, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0};
      vecs[2] = '{8'h0F, 1'b0, 1'b0, 8'h0F, 8'hF0, 1'b0};
      vecs[3] = '{8'h80, 1'b0, 1'b0, 8'h80, 8'h7F, 1'b1};
      vecs[4] = '{8'hFF, 1'b0, 1'b0, 8'hFF, 8'h00, 1'b0};
      vecs[5] = '{8'h00, 1'b0, 1'b0, 8'h00, 8'hFF, 1'b0};
      vecs[6] = '{8'h01, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0};
      vecs[7] = '{8'h6E, 1'b0, 1'b0, 8'h6E, 8'h91, 1'b1};

      #1;
      apply_reset("reset");

      // ---- isolated frames from the table; echo starts two cycles after stop
      n_good = 0;
      for (int i = 0; i < NV; i++) begin
         send_frame(vecs[i].data, vecs[i].stop);
         check("tbl_frame_err",       32'(ferr0), 32'(vecs[i].exp_err));
         check("tbl_frame_err_mask",  32'(ferr1), 32'(vecs[i].exp_err));
         check("tbl_a_idle_at_stop",  32'({a1, a0}), 32'd0);
         for (int c = 0; c < 12; c++) begin
            step(1'b0, 1'b0, 8'h00);
            cap0[c] = a0;
            cap1[c] = a1;
            if (c == 0) check("tbl_err_one_cycle", 32'({ferr1, ferr0}), 32'd0);
         end
         if (vecs[i].exp_err) begin
            check("tbl_no_echo",       32'({cap1, cap0}), 32'd0);
            check("tbl_no_push_level", 32'(lvl0), 32'd0);
         end else begin
            n_good++;
            check("tbl_echo_plain",  32'(cap0), 32'({2'b00, vecs[i].exp_par, vecs[i].exp_w0, 1'b1}));
            check("tbl_echo_masked", 32'(cap1), 32'({2'b00, vecs[i].exp_par, vecs[i].exp_w1, 1'b1}));
         end
         check("tbl_frames_rx", 32'(frx0), 32'(n_good));
      end

      // ---- reset in the middle of an RX frame and a TX frame
      apply_reset("reset2");
      send_frame(8'hFF, 1'b0);
      step(1'b1, 1'b0, 8'h00);              // start of a second frame
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'h00);
      check("midframe_a_busy", 32'(a0), 32'd1);
      apply_reset("reset_mid");
      send_frame(8'h5A, 1'b0);
      idle(14);
      check("after_reset_frames_rx", 32'(frx0), 32'd1);

      // ---- sustained back-to-back input: full FIFO with simultaneous pop,
      //      then a drop into the still-full FIFO
      apply_reset("reset3");
      for (int i = 0; i < 24; i++) send_frame(8'($urandom), 1'b0);
      idle(1);                               // aligns frame 24's stop with a pop
      send_frame(8'($urandom), 1'b0);
      check("full_pop_no_overflow", 32'({ovf1, ovf0}), 32'd0);
      check("full_pop_level",       32'(lvl0), 32'd4);
      check("full_pop_frames_rx",   32'(frx0), 32'd25);
      send_frame(8'($urandom), 1'b0);
      check("drop_overflow",        32'({ovf1, ovf0}), 32'h3);
      check("drop_level",           32'(lvl0), 32'd4);
      check("drop_frames_rx",       32'(frx0), 32'd25);
      idle(6 * TX_PER);
      check("drain_level",          32'(lvl0), 32'd0);
      check("drain_overflow_sticky", 32'(ovf0), 32'd1);

      // ---- random frames, gaps and stop-bit errors against the model
      apply_reset("reset4");
      for (int i = 0; i < 60; i++) begin
         idle(int'($urandom_range(0, 14)));
         send_frame(8'($urandom), ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
      end
      idle(6 * TX_PER);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_serial_echo_device
